// File: rtl/sync_r2w_level_if.sv
// Signal bundle between a FIFO write-side controller and the read-pointer
// synchronizer / level calculator.
interface sync_r2w_level_if #(
    parameter int ASIZE = 4
);
    logic [ASIZE:0] rptr;
    logic [ASIZE:0] wbin;
    logic [ASIZE:0] walmost_thresh;
    logic           werr_clr;

    logic [ASIZE:0] wq_rptr;
    logic [ASIZE:0] wrbin;
    logic [ASIZE:0] wlevel;
    logic           wfull;
    logic           walmost_full;
    logic           wupd;
    logic           werr_gray;
    logic           werr_ovf;

    modport master (
        output rptr, wbin, walmost_thresh, werr_clr,
        input  wq_rptr, wrbin, wlevel, wfull, walmost_full, wupd, werr_gray, werr_ovf
    );

    modport slave (
        input  rptr, wbin, walmost_thresh, werr_clr,
        output wq_rptr, wrbin, wlevel, wfull, walmost_full, wupd, werr_gray, werr_ovf
    );
endinterface

// File: rtl/sync_r2w_level.sv
// Brings the Gray read pointer into the write clock domain and derives the
// write-side occupancy, full/almost-full flags and sticky integrity errors.
module sync_r2w_level #(
    parameter int ASIZE  = 4,
    parameter int STAGES = 2
) (
    input  logic              wclk,
    input  logic              wrst_n,
    sync_r2w_level_if.slave   bus
);
    localparam logic [ASIZE:0] DEPTH = {1'b1, {ASIZE{1'b0}}};

    logic [ASIZE:0] sync_q [STAGES];
    logic [ASIZE:0] sync_d [STAGES];
    logic [ASIZE:0] wq_rptr;
    logic [ASIZE:0] rbin;
    logic [ASIZE:0] gray_diff;

    logic [ASIZE:0] wq_prev_q, wq_prev_d;
    logic [ASIZE:0] wrbin_q, wrbin_d;
    logic [ASIZE:0] wlevel_q, wlevel_d;
    logic           wfull_q, wfull_d;
    logic           walmost_full_q, walmost_full_d;
    logic           wupd_q, wupd_d;
    logic           werr_gray_q, werr_gray_d;
    logic           werr_ovf_q, werr_ovf_d;

    assign wq_rptr = sync_q[STAGES-1];

    // Each binary bit is the XOR of all Gray bits at or above it.
    genvar gi;
    generate
        for (gi = 0; gi <= ASIZE; gi++) begin : g_g2b
            assign rbin[gi] = ^wq_rptr[ASIZE:gi];
        end
    endgenerate

    always_comb begin
        sync_d[0] = bus.rptr;
        for (int k = 1; k < STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
    end

    always_comb begin
        wq_prev_d      = wq_rptr;
        wrbin_d        = rbin;
        wlevel_d       = bus.wbin - rbin;
        wfull_d        = (wlevel_d == DEPTH);
        walmost_full_d = (wlevel_d >= bus.walmost_thresh);
        gray_diff      = wq_rptr ^ wq_prev_q;
        wupd_d         = |gray_diff;
        // A set condition wins over a simultaneous clear.
        werr_gray_d    = ((gray_diff & (gray_diff - 1'b1)) != '0) ||
                         (werr_gray_q && !bus.werr_clr);
        werr_ovf_d     = (wlevel_d > DEPTH) || (werr_ovf_q && !bus.werr_clr);
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                sync_q[k] <= '0;
            end
            wq_prev_q      <= '0;
            wrbin_q        <= '0;
            wlevel_q       <= '0;
            wfull_q        <= 1'b0;
            walmost_full_q <= 1'b0;
            wupd_q         <= 1'b0;
            werr_gray_q    <= 1'b0;
            werr_ovf_q     <= 1'b0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                sync_q[k] <= sync_d[k];
            end
            wq_prev_q      <= wq_prev_d;
            wrbin_q        <= wrbin_d;
            wlevel_q       <= wlevel_d;
            wfull_q        <= wfull_d;
            walmost_full_q <= walmost_full_d;
            wupd_q         <= wupd_d;
            werr_gray_q    <= werr_gray_d;
            werr_ovf_q     <= werr_ovf_d;
        end
    end

    assign bus.wq_rptr      = wq_rptr;
    assign bus.wrbin        = wrbin_q;
    assign bus.wlevel       = wlevel_q;
    assign bus.wfull        = wfull_q;
    assign bus.walmost_full = walmost_full_q;
    assign bus.wupd         = wupd_q;
    assign bus.werr_gray    = werr_gray_q;
    assign bus.werr_ovf     = werr_ovf_q;
endmodule

// File: tb/tb_sync_r2w_level.sv
// Scoreboard bench for sync_r2w_level: directed scenarios plus a random walk,
// with expectations derived from a cycle-history model of the read pointer.
module tb_sync_r2w_level;
    localparam int ASIZE  = 4;
    localparam int STAGES = 2;
    localparam int PW     = ASIZE + 1;
    localparam int DEPTH  = 1 << ASIZE;

    logic wclk   = 1'b0;
    logic wrst_n = 1'b1;
    always #5 wclk = ~wclk;

    sync_r2w_level_if #(.ASIZE(ASIZE)) bus ();

    sync_r2w_level #(.ASIZE(ASIZE), .STAGES(STAGES)) dut (
        .wclk   (wclk),
        .wrst_n (wrst_n),
        .bus    (bus.slave)
    );

    typedef struct {
        logic [PW-1:0] wq;
        logic [PW-1:0] wrbin;
        logic [PW-1:0] wlevel;
        logic          wfull;
        logic          walm;
        logic          wupd;
        logic          egray;
        logic          eovf;
    } exp_t;

    exp_t          sbq [$];
    logic [PW-1:0] rq  [$];   // rptr value sampled at each edge, oldest first
    logic          egray_m;
    logic          eovf_m;
    int            n_vec = 0;
    int            n_err = 0;

    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Binary value found by searching for the count whose Gray code matches.
    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        for (int i = 0; i < (1 << PW); i++) begin
            if (bin2gray(PW'(i)) == g) return PW'(i);
        end
        return '0;
    endfunction

    function automatic int popcount(input logic [PW-1:0] v);
        int c = 0;
        for (int i = 0; i < PW; i++) c += int'(v[i]);
        return c;
    endfunction

    task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0b, required %0b (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_wq"},     bus.wq_rptr, '0);
        chk({tag, "_wrbin"},  bus.wrbin,   '0);
        chk({tag, "_wlevel"}, bus.wlevel,  '0);
        chk1({tag, "_wfull"}, bus.wfull, 1'b0);
        chk1({tag, "_walm"},  bus.walmost_full, 1'b0);
        chk1({tag, "_wupd"},  bus.wupd, 1'b0);
        chk1({tag, "_egray"}, bus.werr_gray, 1'b0);
        chk1({tag, "_eovf"},  bus.werr_ovf, 1'b0);
    endtask

    task automatic model_reset();
        rq.delete();
        for (int i = 0; i < STAGES + 2; i++) rq.push_back('0);
        egray_m = 1'b0;
        eovf_m  = 1'b0;
        sbq.delete();
    endtask

    // Drive one cycle of inputs and queue what the outputs must be after the edge.
    task automatic step(input logic [PW-1:0] r, input logic [PW-1:0] wb,
                        input logic [PW-1:0] th, input logic clr);
        exp_t          e;
        int            n, lvl;
        logic [PW-1:0] p1, p2;
        @(negedge wclk);
        bus.rptr           = r;
        bus.wbin           = wb;
        bus.walmost_thresh = th;
        bus.werr_clr       = clr;
        rq.push_back(r);
        void'(rq.pop_front());
        n  = rq.size();
        e.wq    = rq[n-STAGES];      // sampled STAGES-1 edges ago
        p1      = rq[n-STAGES-1];    // synchronized value one edge earlier
        p2      = rq[n-STAGES-2];
        e.wrbin = gray2bin(p1);
        lvl     = (int'(wb) - int'(gray2bin(p1)) + 2*DEPTH) % (2*DEPTH);
        e.wlevel = PW'(lvl);
        e.wfull  = (lvl == DEPTH);
        e.walm   = (lvl >= int'(th));
        e.wupd   = (p1 != p2);
        egray_m  = (popcount(p1 ^ p2) > 1) || (egray_m && !clr);
        eovf_m   = (lvl > DEPTH) || (eovf_m && !clr);
        e.egray  = egray_m;
        e.eovf   = eovf_m;
        sbq.push_back(e);
    endtask

    task automatic after_edge();
        @(posedge wclk);
        #2;
    endtask

    task automatic do_reset(input string tag);
        @(posedge wclk);
        #3;
        wrst_n = 1'b0;
        #1;
        chk_zero(tag);
        model_reset();
        @(posedge wclk);
        #2;
        wrst_n = 1'b1;
    endtask

    exp_t m;
    always begin
        @(posedge wclk);
        #1;
        if (wrst_n === 1'b1 && sbq.size() > 0) begin
            m = sbq.pop_front();
            chk("sb_wq",     bus.wq_rptr, m.wq);
            chk("sb_wrbin",  bus.wrbin,   m.wrbin);
            chk("sb_wlevel", bus.wlevel,  m.wlevel);
            chk1("sb_wfull", bus.wfull,   m.wfull);
            chk1("sb_walm",  bus.walmost_full, m.walm);
            chk1("sb_wupd",  bus.wupd,    m.wupd);
            chk1("sb_egray", bus.werr_gray, m.egray);
            chk1("sb_eovf",  bus.werr_ovf,  m.eovf);
        end
    end

    initial begin
        logic [PW-1:0] rb, wb;
        bus.rptr = '0; bus.wbin = '0; bus.walmost_thresh = '0; bus.werr_clr = 1'b0;
        model_reset();
        #2 wrst_n = 1'b0;
        #1 chk_zero("rst_init");
        @(posedge wclk);
        #2 wrst_n = 1'b1;

        // Fill: full at DEPTH, almost-full without full at the threshold
        step(5'd0, 5'd16, 5'd14, 1'b0); after_edge();
        chk("fill_lvl", bus.wlevel, 5'd16);
        chk1("fill_full", bus.wfull, 1'b1);
        step(5'd0, 5'd14, 5'd14, 1'b0); after_edge();
        chk1("alm_alm", bus.walmost_full, 1'b1);
        chk1("alm_full", bus.wfull, 1'b0);

        // Overflow: sticky until cleared
        step(5'd0, 5'd17, 5'd14, 1'b0); after_edge();
        chk1("ovf_set", bus.werr_ovf, 1'b1);
        chk("ovf_lvl", bus.wlevel, 5'd17);
        for (int i = 0; i < 3; i++) step(5'd0, 5'd5, 5'd14, 1'b0);
        after_edge();
        chk1("ovf_hold", bus.werr_ovf, 1'b1);
        step(5'd0, 5'd5, 5'd14, 1'b1); after_edge();
        chk1("ovf_clr", bus.werr_ovf, 1'b0);

        // Latency: wq after STAGES edges, wrbin/wupd one edge later
        step(5'd1, 5'd0, 5'd20, 1'b0);
        step(5'd1, 5'd0, 5'd20, 1'b0); after_edge();
        chk("lat_wq", bus.wq_rptr, 5'd1);
        chk1("lat_wupd_early", bus.wupd, 1'b0);
        step(5'd1, 5'd0, 5'd20, 1'b0); after_edge();
        chk("lat_wrbin", bus.wrbin, 5'd1);
        chk1("lat_wupd", bus.wupd, 1'b1);
        step(5'd1, 5'd0, 5'd20, 1'b0); after_edge();
        chk1("lat_wupd_end", bus.wupd, 1'b0);

        // Reset with a pointer in flight
        step(5'b00110, 5'd5, 5'd20, 1'b0);
        do_reset("rst_mid");
        step(5'b00110, 5'd5, 5'd20, 1'b0); after_edge();
        chk("rel_wq0", bus.wq_rptr, 5'd0);
        chk1("rel_wupd0", bus.wupd, 1'b0);
        step(5'b00110, 5'd5, 5'd20, 1'b0); after_edge();
        chk("rel_wq", bus.wq_rptr, 5'b00110);
        chk1("rel_wupd1", bus.wupd, 1'b0);

        // Gray error: set, clear, set-beats-clear
        do_reset("rst_gray");
        for (int i = 0; i < 3; i++) step(5'b00011, 5'd2, 5'd20, 1'b0);
        after_edge();
        chk1("gray_set", bus.werr_gray, 1'b1);
        step(5'b00011, 5'd2, 5'd20, 1'b1); after_edge();
        chk1("gray_clr", bus.werr_gray, 1'b0);
        for (int i = 0; i < 3; i++) step(5'd0, 5'd0, 5'd20, 1'b1);
        after_edge();
        chk1("gray_setwin", bus.werr_gray, 1'b1);

        // Wrap through 31 -> 0 with a constant level of 3
        for (int i = 0; i < 4; i++) step(bin2gray(5'd28), 5'd31, 5'd20, 1'b1);
        rb = 5'd28;
        for (int s = 0; s < 5; s++) begin
            rb = rb + 5'd1;
            for (int i = 0; i < 4; i++) step(bin2gray(rb), rb + 5'd3, 5'd20, 1'b0);
            after_edge();
            chk("wrap_lvl", bus.wlevel, 5'd3);
        end
        chk1("wrap_egray", bus.werr_gray, 1'b0);
        chk1("wrap_eovf", bus.werr_ovf, 1'b0);

        // Random walk with occasional illegal jumps and clears
        do_reset("rst_rand");
        rb = '0;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) == 0) rb = PW'($urandom);
            else                           rb = rb + PW'($urandom_range(0, 1));
            wb = rb + PW'($urandom_range(0, 18));
            step(bin2gray(rb), wb, PW'($urandom_range(0, 20)), ($urandom_range(0, 7) == 0));
        end

        repeat (2) @(posedge wclk);
        #3;
        n_vec++;
        if (sbq.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain: %0d entries left, required 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/sync_r2w_level.md
SYNC_R2W_LEVEL -- requirements
Module: sync_r2w_level

Interface
REQ-001 The module SHALL have parameter ASIZE, default 4: address width; FIFO depth DEPTH = 2^ASIZE; pointers are ASIZE+1 bits.
REQ-002 The module SHALL have parameter STAGES, default 2: synchronizer flop count; legal values 2..4.
REQ-003 The module SHALL have input wclk, 1 bit: the single clock, the write-domain clock.
REQ-004 The module SHALL have input wrst_n, 1 bit: reset, asynchronous and active-low.
REQ-005 The module SHALL have input rptr, ASIZE+1 bits: Gray-coded read pointer from the foreign domain.
REQ-006 The module SHALL have input wbin, ASIZE+1 bits: local binary write pointer, already in the wclk domain.
REQ-007 The module SHALL have input walmost_thresh, ASIZE+1 bits: almost-full threshold, in entries.
REQ-008 The module SHALL have input werr_clr, 1 bit: synchronous clear of the sticky error flags.
REQ-009 The module SHALL have output wq_rptr, ASIZE+1 bits: rptr after the last synchronizer stage, in Gray code.
REQ-010 The module SHALL have output wrbin, ASIZE+1 bits: wq_rptr converted to binary, registered.
REQ-011 The module SHALL have output wlevel, ASIZE+1 bits: FIFO occupancy seen from the write side, registered.
REQ-012 The module SHALL have output wfull, 1 bit: wlevel == DEPTH, registered.
REQ-013 The module SHALL have output walmost_full, 1 bit: wlevel >= walmost_thresh, registered.
REQ-014 The module SHALL have output wupd, 1 bit: one-cycle pulse when wq_rptr changed on the previous edge.
REQ-015 The module SHALL have output werr_gray, 1 bit: sticky flag; the synchronized pointer moved by more than one bit.
REQ-016 The module SHALL have output werr_ovf, 1 bit: sticky flag; computed wlevel exceeded DEPTH.

Function
REQ-017 The synchronizer SHALL be a STAGES-deep shift chain of ASIZE+1-bit flops: stage1 <= rptr, stage k <= stage k-1, wq_rptr = last stage; no logic between stages.
REQ-018 A stable rptr value SHALL appear on wq_rptr exactly STAGES wclk edges after it is first sampled.
REQ-019 An internal register wq_prev SHALL hold the previous wq_rptr value every cycle.
REQ-020 The Gray-to-binary conversion SHALL be: b[ASIZE] = g[ASIZE], b[i] = b[i+1] XOR g[i]; the result is registered into wrbin one edge after wq_rptr.
REQ-021 wlevel SHALL be registered from (wbin - bin(wq_rptr)) modulo 2^(ASIZE+1), using the current wbin, so wlevel, wfull, walmost_full and wrbin share latency STAGES+1 relative to rptr.
REQ-022 wfull and walmost_full SHALL be computed from the same next-wlevel value in the same edge, with no extra cycle of delay.
REQ-023 wupd SHALL be registered as (wq_rptr != wq_prev): a single-cycle pulse, aligned with the wrbin update.
REQ-024 werr_gray SHALL set when popcount(wq_rptr XOR wq_prev) > 1.
REQ-025 werr_ovf SHALL set when the next wlevel > DEPTH.
REQ-026 Once set, werr_gray and werr_ovf SHALL stay set until werr_clr is sampled high.
REQ-027 When werr_clr and a new set condition occur in the same cycle, the set SHALL take precedence and the flag SHALL remain 1.
REQ-028 Pointer wrap-around (2^(ASIZE+1)-1 -> 0 in binary, i.e. the Gray MSB-only change) SHALL be treated as a legal single-bit step, and the level arithmetic SHALL be modular with no special case.
REQ-029 The module SHALL NOT gate or hold wbin; wbin changes are reflected in wlevel on the next edge, with a latency of 1.

Reset
REQ-030 On wrst_n low, all synchronizer stages, wq_prev, wq_rptr, wrbin and wlevel SHALL go to 0 immediately, without waiting for wclk.
REQ-031 On wrst_n low, wfull, wupd, werr_gray and werr_ovf SHALL go to 0 immediately.
REQ-032 On wrst_n low, walmost_full SHALL go to 0 immediately, regardless of walmost_thresh.
REQ-033 Reset asserted mid-operation SHALL discard any in-flight pointer values, with no pulse on wupd after release.
REQ-034 After wrst_n rises, the first valid sync output SHALL appear STAGES edges after rptr is sampled.

Verification
REQ-035 Latency scenario (ASIZE=4, STAGES=2, wbin=0): step rptr 0 -> Gray(1)=00001 -> wq_rptr=00001 after 2 edges; wrbin=1 and wupd=1 after 3 edges; wupd=0 on the next edge.
REQ-036 Fill scenario: rptr=0, wbin=16 -> after 1 edge wlevel=16 and wfull=1; with walmost_thresh=14 and wbin=14 -> walmost_full=1 and wfull=0.
REQ-037 Wrap scenario: rptr walks through Gray codes 30 -> 31 -> 0 while wbin = rbin + 3 -> wlevel stays 3, werr_gray=0, werr_ovf=0.
REQ-038 Gray error scenario: rptr jumps 00000 -> 00011 -> werr_gray=1 at edge 3; werr_clr pulsed -> werr_gray=0; werr_clr held high while a new 2-bit jump arrives -> werr_gray=1.
REQ-039 Overflow scenario: rptr=0, wbin=17 -> werr_ovf=1 and wlevel=17; it stays 1 after wbin returns to 5 until werr_clr is pulsed.
REQ-040 Reset scenario: wrst_n pulsed low between edges with rptr in flight -> all outputs 0 immediately, no wupd pulse after release, and normal STAGES latency after release.
